// File: rtl/alu_if.sv
// alu_if: operand/opcode inputs and registered result/flag outputs of the ALU
interface alu_if;
  logic [4:0]  opcode;
  logic [31:0] operando_a;
  logic [31:0] operando_b;
  logic [31:0] resultado;
  logic        C;
  logic        S;
  logic        O;
  logic        Z;
  modport master (output opcode, operando_a, operando_b, input resultado, C, S, O, Z);
  modport slave  (input opcode, operando_a, operando_b, output resultado, C, S, O, Z);
endinterface

// File: rtl/alu.sv
// alu: single-cycle registered 32-bit ALU with carry/sign/overflow/zero flags
module alu (
  input logic   clk,
  input logic   rst_n,
  alu_if.slave  bus
);
  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5;
  localparam logic [4:0] OP_NOT = 5'd6;
  localparam logic [4:0] OP_SHL = 5'd7;
  localparam logic [4:0] OP_SHR = 5'd8;
  localparam logic [4:0] OP_SAR = 5'd9;
  localparam logic [4:0] OP_INC = 5'd10;
  localparam logic [4:0] OP_DEC = 5'd11;
  localparam logic [4:0] OP_CMP = 5'd12;
  localparam logic [4:0] OP_MOV = 5'd13;
  localparam logic [4:0] OP_NEG = 5'd14;
  logic [31:0] w_x, w_y, w_res;
  logic [32:0] w_sum, w_dif, w_shl, w_shr, w_sar;
  logic [4:0]  w_n;
  logic        w_c, w_o, w_wr_res, w_wr_flg;
  logic [31:0] r_res;
  logic        r_c, r_s, r_o, r_z;
  // Steer operands into the shared adder/subtractor; unary ops never select operando_b
  always_comb begin
    w_n   = bus.operando_b[4:0];
    w_x   = bus.opcode == OP_NEG ? 32'd0 : bus.operando_a;
    w_y   = (bus.opcode == OP_INC || bus.opcode == OP_DEC) ? 32'd1 :
            bus.opcode == OP_NEG ? bus.operando_a : bus.operando_b;
    w_sum = {1'b0, w_x} + {1'b0, w_y};
    w_dif = {1'b0, w_x} - {1'b0, w_y};
    w_shl = {1'b0, bus.operando_a} << w_n;
    w_shr = {bus.operando_a, 1'b0} >> w_n;
    w_sar = $signed({bus.operando_a, 1'b0}) >>> w_n;
  end
  // Select result and flags; the extra shifter bit catches the last bit shifted out
  always_comb begin
    w_res    = '0;
    w_c      = 1'b0;
    w_o      = 1'b0;
    w_wr_res = 1'b1;
    w_wr_flg = 1'b1;
    case (bus.opcode)
      OP_ADD, OP_INC: begin
        w_res = w_sum[31:0];
        w_c   = w_sum[32];
        w_o   = (w_x[31] == w_y[31]) && (w_sum[31] != w_x[31]);
      end
      OP_SUB, OP_DEC, OP_CMP, OP_NEG: begin
        w_res    = w_dif[31:0];
        w_c      = w_dif[32];
        w_o      = (w_x[31] != w_y[31]) && (w_dif[31] != w_x[31]);
        w_wr_res = bus.opcode != OP_CMP;
      end
      OP_AND: w_res = bus.operando_a & bus.operando_b;
      OP_OR:  w_res = bus.operando_a | bus.operando_b;
      OP_XOR: w_res = bus.operando_a ^ bus.operando_b;
      OP_NOT: w_res = ~bus.operando_a;
      OP_MOV: w_res = bus.operando_a;
      OP_SHL: begin
        w_res = w_shl[31:0];
        w_c   = w_shl[32];
      end
      OP_SHR: begin
        w_res = w_shr[32:1];
        w_c   = w_shr[0];
      end
      OP_SAR: begin
        w_res = w_sar[32:1];
        w_c   = w_sar[0];
      end
      default: begin
        w_wr_res = 1'b0;
        w_wr_flg = 1'b0;
      end
    endcase
  end
  // Register result and flags; NOP/undefined hold, CMP updates flags only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res <= '0;
      r_c   <= 1'b0;
      r_s   <= 1'b0;
      r_o   <= 1'b0;
      r_z   <= 1'b0;
    end else begin
      if (w_wr_res) r_res <= w_res;
      if (w_wr_flg) begin
        r_c <= w_c;
        r_s <= w_res[31];
        r_o <= w_o;
        r_z <= w_res == 32'd0;
      end
    end
  end
  assign bus.resultado = r_res;
  assign bus.C         = r_c;
  assign bus.S         = r_s;
  assign bus.O         = r_o;
  assign bus.Z         = r_z;
endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized and directed checks of alu against a behavioural model
module tb_alu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_r = '0;
  logic        m_c = 1'b0, m_s = 1'b0, m_o = 1'b0, m_z = 1'b0;
  alu_if bus();
  alu u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sr;
    longint unsigned ux, uy;
    logic [31:0]     x, y, nr;
    logic            c, o, arith, sub;
    int              sh;
    if (op == 5'd0 || op > 5'd14) return;
    x = a; y = b; nr = '0; c = 1'b0; o = 1'b0; arith = 1'b0; sub = 1'b0;
    sh = int'(b[4:0]);
    case (op)
      5'd1:  arith = 1'b1;
      5'd2:  begin arith = 1'b1; sub = 1'b1; end
      5'd10: begin arith = 1'b1; y = 32'd1; end
      5'd11: begin arith = 1'b1; sub = 1'b1; y = 32'd1; end
      5'd12: begin arith = 1'b1; sub = 1'b1; end
      5'd14: begin arith = 1'b1; sub = 1'b1; x = 32'd0; y = a; end
      5'd3:  nr = a & b;
      5'd4:  nr = a | b;
      5'd5:  nr = a ^ b;
      5'd6:  nr = ~a;
      5'd13: nr = a;
      5'd7:  begin nr = a << sh; c = sh == 0 ? 1'b0 : a[32 - sh]; end
      5'd8:  begin nr = a >> sh; c = sh == 0 ? 1'b0 : a[sh - 1]; end
      default: begin nr = $signed(a) >>> sh; c = sh == 0 ? 1'b0 : a[sh - 1]; end
    endcase
    if (arith) begin
      ux = x; uy = y;
      if (sub) begin
        nr = x - y; c = ux < uy; sr = longint'($signed(x)) - longint'($signed(y));
      end else begin
        nr = x + y; c = (ux + uy) > 64'hFFFF_FFFF; sr = longint'($signed(x)) + longint'($signed(y));
      end
      o = sr > 64'sd2147483647 || sr < -64'sd2147483648;
    end
    if (op != 5'd12) m_r = nr;
    m_c = c; m_s = nr[31]; m_o = o; m_z = nr == 32'd0;
  endtask
  task automatic step(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.opcode = op; bus.operando_a = a; bus.operando_b = b;
    @(posedge clk);
    #1;
    if (!rst_n) {m_r, m_c, m_s, m_o, m_z} = '0;
    else model(op, a, b);
    chk($sformatf("model_op%0d", op), {bus.resultado, bus.C, bus.S, bus.O, bus.Z}, {m_r, m_c, m_s, m_o, m_z});
  endtask
  task automatic dir(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [35:0] exp);
    step(op, a, b);
    chk(tag, {bus.resultado, bus.C, bus.S, bus.O, bus.Z}, exp);
  endtask
  initial begin
    logic [31:0] a, b;
    logic [4:0]  op;
    bus.opcode = '0; bus.operando_a = '0; bus.operando_b = '0;
    dir("reset",     5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 36'h0);
    rst_n = 1'b1;
    dir("nop_rst",   5'd0, 32'h1234_5678, 32'h1, 36'h0);
    dir("add_cov",   5'd1, 32'h8000_0000, 32'h8000_0000, {32'h0000_0000, 4'b1011});
    dir("add_neg",   5'd1, 32'hFFFF_0000, 32'hFFFF_FFFF, {32'hFFFE_FFFF, 4'b1100});
    dir("add_c",     5'd1, 32'hFFFF_0000, 32'h0FFF_1111, {32'h0FFE_1111, 4'b1000});
    dir("add_ov1",   5'd1, 32'h7FFF_0000, 32'h7FFF_1111, {32'hFFFE_1111, 4'b0110});
    dir("add_ov2",   5'd1, 32'h7FFF_0000, 32'h0FFF_1111, {32'h8FFE_1111, 4'b0110});
    dir("not1",      5'd6, 32'hACED_CAFE, 32'hx, {32'h5312_3501, 4'b0000});
    dir("not2",      5'd6, 32'h5312_3501, 32'hx, {32'hACED_CAFE, 4'b0100});
    chk("no_x", {35'd0, $isunknown({bus.resultado, bus.C, bus.S, bus.O, bus.Z})}, 36'd0);
    dir("sub57",     5'd2, 32'd5, 32'd7, {32'hFFFF_FFFE, 4'b1100});
    dir("sub_ov",    5'd2, 32'h8000_0000, 32'd1, {32'h7FFF_FFFF, 4'b0010});
    dir("cmp33",     5'd12, 32'd3, 32'd3, {32'h7FFF_FFFF, 4'b0001});
    dir("shl",       5'd7, 32'h8000_0001, 32'd1, {32'h0000_0002, 4'b1000});
    dir("sar31",     5'd9, 32'h8000_0000, 32'd31, {32'hFFFF_FFFF, 4'b0100});
    dir("undef",     5'd31, 32'h1234, 32'h5678, {32'hFFFF_FFFF, 4'b0100});
    dir("shr_zero",  5'd8, 32'h0000_000F, 32'hFFFF_FFE0, {32'h0000_000F, 4'b0000});
    dir("neg_min",   5'd14, 32'h8000_0000, 32'hx, {32'h8000_0000, 4'b1110});
    dir("dec_zero",  5'd11, 32'd0, 32'hx, {32'hFFFF_FFFF, 4'b1100});
    for (int i = 0; i < 400; i++) begin
      op = 5'($urandom_range(0, 31));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: a = 32'h7FFF_FFFF;
        2: a = 32'hFFFF_FFFF;
        3: a = m_r;
        default: ;
      endcase
      if ($urandom_range(0, 5) == 0) b = {$urandom, 1'b1} ^ {a, 1'b0};
      if (i % 97 == 50) rst_n = 1'b0;
      step(op, a, b);
      rst_n = 1'b1;
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
